// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared op codes, FSM states and default sizing for the muldiv unit
package muldiv_pkg;
  localparam int DEF_WIDTH = 32;
  localparam int LATENCY = DEF_WIDTH + 2;
  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;
  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX
  } state_e;
endpackage

// File: rtl/muldiv_if.sv
// muldiv_if: core-side request/result bundle for the muldiv unit
interface muldiv_if import muldiv_pkg::*; #(parameter int WIDTH = DEF_WIDTH);
  logic start;
  op_e op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic rd_req;
  logic wr_lo;
  logic wr_hi;
  logic [WIDTH-1:0] wdata;
  logic busy;
  logic done;
  logic stall;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] hi;
  modport master (output start, op, a, b, rd_req, wr_lo, wr_hi, wdata, input busy, done, stall, lo, hi);
  modport slave (input start, op, a, b, rd_req, wr_lo, wr_hi, wdata, output busy, done, stall, lo, hi);
endinterface

// File: rtl/muldiv_step.sv
// muldiv_step: one shift-add multiply or restoring divide iteration on the {ph,pl} pair
module muldiv_step #(parameter int WIDTH = 32) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] ph,
  input  logic [WIDTH-1:0] pl,
  input  logic [WIDTH-1:0] m,
  output logic [WIDTH-1:0] ph_n,
  output logic [WIDTH-1:0] pl_n
);
  logic [WIDTH:0] sum;
  logic [WIDTH:0] trial;
  logic ge;
  assign sum = {1'b0, ph} + (pl[0] ? {1'b0, m} : '0);
  assign trial = {ph, pl[WIDTH-1]};
  assign ge = trial >= {1'b0, m};
  assign ph_n = is_div ? (ge ? WIDTH'(trial - {1'b0, m}) : trial[WIDTH-1:0]) : sum[WIDTH:1];
  assign pl_n = is_div ? {pl[WIDTH-2:0], ge} : {sum[0], pl[WIDTH-1:1]};
endmodule

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers and core stall
module muldiv_sequencer import muldiv_pkg::*; #(parameter int WIDTH = DEF_WIDTH) (
  input logic clk,
  input logic reset,
  muldiv_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);
  state_e state, state_n;
  logic [CW-1:0] cnt;
  logic is_div, neg_res, neg_rem, dz, sgn, accept, last;
  logic [WIDTH-1:0] ph, pl, m, ph_n, pl_n, ua, ub, res_lo, res_hi;
  logic [2*WIDTH-1:0] prod;
  muldiv_step #(.WIDTH(WIDTH)) u_step (.is_div(is_div), .ph(ph), .pl(pl), .m(m), .ph_n(ph_n), .pl_n(pl_n));
  assign sgn = ~bus.op[0];
  assign ua = sgn && bus.a[WIDTH-1] ? -bus.a : bus.a;
  assign ub = sgn && bus.b[WIDTH-1] ? -bus.b : bus.b;
  assign accept = state == IDLE && bus.start;
  assign last = cnt == CW'(WIDTH);
  assign prod = neg_res ? -{ph, pl} : {ph, pl};
  assign res_lo = is_div ? (dz ? '1 : neg_res ? -pl : pl) : prod[WIDTH-1:0];
  assign res_hi = is_div ? (neg_rem ? -ph : ph) : prod[2*WIDTH-1:WIDTH];
  assign bus.busy = state != IDLE;
  assign bus.stall = bus.busy & (bus.start | bus.rd_req | bus.wr_lo | bus.wr_hi);
  always_ff @(posedge clk) state <= reset ? IDLE : state_n;
  always_comb begin
    state_n = state == IDLE ? (bus.start ? RUN : IDLE) : state == RUN ? (last ? FIX : RUN) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      is_div <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      dz <= 1'b0;
      ph <= '0;
      pl <= '0;
      m <= '0;
      bus.done <= 1'b0;
      bus.lo <= '0;
      bus.hi <= '0;
    end else begin
      bus.done <= state == FIX;
      if (accept) begin
        cnt <= '0;
        is_div <= bus.op[1];
        neg_res <= sgn & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
        neg_rem <= sgn & bus.a[WIDTH-1];
        dz <= bus.b == '0;
        ph <= '0;
        pl <= bus.op[1] ? ua : ub;
        m <= bus.op[1] ? ub : ua;
      end else if (state == RUN && !last) begin
        ph <= ph_n;
        pl <= pl_n;
        cnt <= cnt + CW'(1);
      end
      if (state == FIX) begin
        bus.lo <= res_lo;
        bus.hi <= res_hi;
      end else if (state == IDLE) begin
        if (bus.wr_lo) bus.lo <= bus.wdata;
        if (bus.wr_hi) bus.hi <= bus.wdata;
      end
    end
  end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: directed and random checks of muldiv_sequencer against an arithmetic model
module tb_muldiv_sequencer;
  import muldiv_pkg::*;
  localparam int W = 32;
  logic clk = 1'b0;
  logic reset;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  muldiv_if #(.WIDTH(W)) bus ();
  muldiv_sequencer #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));
  function automatic logic [63:0] model(op_e op, logic [31:0] a, logic [31:0] b);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (op == OP_MULT) return 64'(sa * sb);
    if (op == OP_MULTU) return {32'd0, a} * {32'd0, b};
    if (b == 0) return {a, 32'hFFFF_FFFF};
    if (op == OP_DIV) return {32'(sa % sb), 32'(sa / sb)};
    return {a % b, a / b};
  endfunction
  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic launch(op_e op, logic [31:0] a, logic [31:0] b);
    bus.start = 1'b1;
    bus.op = op;
    bus.a = a;
    bus.b = b;
    @(negedge clk);
    bus.start = 1'b0;
    bus.a = $urandom;
    bus.b = $urandom;
  endtask
  task automatic wait_done(output int n, output int bn);
    n = 0;
    bn = 0;
    while (!bus.done && n < 100) begin
      if (bus.busy) bn++;
      @(negedge clk);
      n++;
    end
  endtask
  task automatic run_op(op_e op, logic [31:0] a, logic [31:0] b, logic [63:0] exp, string tag);
    int n, bn;
    launch(op, a, b);
    wait_done(n, bn);
    check({tag, " latency"}, 64'(n), 64'(LATENCY));
    check({tag, " busy_cycles"}, 64'(bn), 64'(LATENCY));
    check({tag, " hi_lo"}, {bus.hi, bus.lo}, exp);
  endtask
  initial begin
    int n, bn;
    op_e rop;
    logic [31:0] ra, rb;
    reset = 1'b1;
    bus.start = 1'b0;
    bus.op = OP_MULT;
    bus.a = '0;
    bus.b = '0;
    bus.rd_req = 1'b0;
    bus.wr_lo = 1'b0;
    bus.wr_hi = 1'b0;
    bus.wdata = '0;
    repeat (3) @(negedge clk);
    check("reset state", {60'd0, bus.busy, bus.done, bus.stall, 1'b0}, 64'd0);
    check("reset hi_lo", {bus.hi, bus.lo}, 64'd0);
    reset = 1'b0;
    @(negedge clk);
    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, "multu_max");
    @(negedge clk);
    check("done one cycle", {62'd0, bus.done, bus.busy}, 64'd0);
    run_op(OP_MULT, 32'hFFFF_FFFD, 32'd7, 64'hFFFF_FFFF_FFFF_FFEB, "mult_neg_pos");
    run_op(OP_MULT, 32'hFFFF_FFFD, 32'hFFFF_FFF9, 64'h0000_0000_0000_0015, "mult_neg_neg");
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD, "div_neg_pos");
    run_op(OP_DIVU, 32'd7, 32'd2, 64'h0000_0001_0000_0003, "divu_7_2");
    run_op(OP_DIV, 32'd7, 32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD, "div_pos_neg");
    run_op(OP_DIV, 32'd5, 32'd0, 64'h0000_0005_FFFF_FFFF, "div_by_zero");
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd0, 64'hFFFF_FFF9_FFFF_FFFF, "div_neg_by_zero");
    run_op(OP_DIVU, 32'h8000_0003, 32'd0, 64'h8000_0003_FFFF_FFFF, "divu_by_zero");
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, "div_overflow");
    for (int i = 0; i < 16; i++) begin
      rop = op_e'($urandom_range(0, 3));
      ra = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      rb = ($urandom_range(0, 7) == 0) ? 32'd0 : ($urandom_range(0, 3) == 0 ? $urandom_range(1, 300) : $urandom);
      run_op(rop, ra, rb, model(rop, ra, rb), $sformatf("rand%0d_op%0d", i, rop));
    end
    @(negedge clk);
    launch(OP_MULTU, 32'd3, 32'd4);
    repeat (4) @(negedge clk);
    check("busy no request stall", {63'd0, bus.stall}, 64'd0);
    bus.rd_req = 1'b1;
    #1 check("rd_req stall", {63'd0, bus.stall}, 64'd1);
    @(negedge clk);
    bus.rd_req = 1'b0;
    bus.start = 1'b1;
    bus.op = OP_DIVU;
    bus.a = 32'd9;
    bus.b = 32'd2;
    bus.wr_lo = 1'b1;
    bus.wr_hi = 1'b1;
    bus.wdata = 32'h5555_5555;
    #1 check("busy start stall", {63'd0, bus.stall}, 64'd1);
    @(negedge clk);
    bus.start = 1'b0;
    bus.wr_lo = 1'b0;
    bus.wr_hi = 1'b0;
    wait_done(n, bn);
    check("ignored start result", {bus.hi, bus.lo}, 64'h0000_0000_0000_000C);
    run_op(OP_DIVU, 32'd9, 32'd2, 64'h0000_0001_0000_0004, "back_to_back");
    bus.wr_lo = 1'b1;
    bus.wdata = 32'h0000_ABCD;
    @(negedge clk);
    bus.wr_lo = 1'b0;
    check("mtlo", {bus.hi, bus.lo}, 64'h0000_0001_0000_ABCD);
    bus.wr_hi = 1'b1;
    bus.wdata = 32'h1234_5678;
    @(negedge clk);
    bus.wr_hi = 1'b0;
    check("mthi", {bus.hi, bus.lo}, 64'h1234_5678_0000_ABCD);
    bus.rd_req = 1'b1;
    #1 check("idle no stall", {63'd0, bus.stall}, 64'd0);
    bus.rd_req = 1'b0;
    bus.wr_lo = 1'b1;
    bus.wdata = 32'd77;
    launch(OP_MULTU, 32'd2, 32'd3);
    bus.wr_lo = 1'b0;
    check("start with mtlo", {32'd0, bus.lo}, 64'd77);
    wait_done(n, bn);
    check("start with mtlo result", {bus.hi, bus.lo}, 64'd6);
    launch(OP_MULT, $urandom, $urandom);
    repeat (8) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort state", {61'd0, bus.busy, bus.done, bus.stall}, 64'd0);
    check("abort hi_lo", {bus.hi, bus.lo}, 64'd0);
    n = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) n++;
    end
    check("abort no done", 64'(n), 64'd0);
    ra = $urandom;
    rb = $urandom_range(1, 1000);
    run_op(OP_DIVU, ra, rb, model(OP_DIVU, ra, rb), "after_abort");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
